cfg_avmm_csr_slave: RTL and testbench

- AVMM configuration slave. Terminates the adapter's per-channel config bus: i_cfg_avmm_* in, o_cfg_avmm_rdata/rdatavld/waitreq out.
- Holds a small CSR file: one W1C sticky status register plus RW control registers.
- Inserts a programmable number of wait states per access. Returns read data one cycle after acceptance.
- Exports all CSR contents as a flat vector to the downstream datapath.

---
 rtl/cfg_avmm_csr_slave.sv | 192 +++++++++++++++++++
 tb/tb_cfg_avmm_csr_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_avmm_csr_slave.sv
// -----------------------------------------------------------------------------
// cfg_avmm_csr_slave
//
// Purpose:
//   Terminates the adapter's per-channel AVMM configuration bus. Holds a small
//   CSR file (register 0 is a W1C sticky status register, the rest are plain
//   RW control registers), inserts a fixed number of wait states per access,
//   and exports every CSR as one flat vector to the downstream datapath.
//
// Handshake:
//   The master raises read and/or write with address/data and holds all of
//   them stable while o_cfg_avmm_waitreq is high. A command is accepted on the
//   rising edge of a cycle in which a request is present and waitreq is low;
//   that happens exactly WAIT_CYCLES cycles after the request first appears.
//   Read data comes back as a one-cycle o_cfg_avmm_rdatavld pulse in the cycle
//   after acceptance; o_cfg_avmm_rdata is zero whenever rdatavld is low.
//
// Ports:
//   i_cfg_avmm_clk       config clock, the only clock in the block
//   i_cfg_avmm_rst_n     asynchronous, active-low reset
//   i_cfg_avmm_addr      byte address; word index is addr[16:2]
//   i_cfg_avmm_byte_en   write byte enables
//   i_cfg_avmm_read      read request
//   i_cfg_avmm_write     write request (wins when both are high)
//   i_cfg_avmm_wdata     write data
//   o_cfg_avmm_rdata     read data
//   o_cfg_avmm_rdatavld  read data valid, one-cycle pulse
//   o_cfg_avmm_waitreq   stall
//   i_status_set         per-bit set pulses into status register 0
//   o_csr_flat           register k on bits [32k+31:32k]
//   o_err_cnt            saturating count of decode and protocol errors
//   o_fsm_state          access FSM state (0 idle, 1 wait, 2 ack) for debug
// -----------------------------------------------------------------------------
module cfg_avmm_csr_slave #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_C0DE
) (
  input  logic                     i_cfg_avmm_clk,
  input  logic                     i_cfg_avmm_rst_n,
  input  logic [16:0]              i_cfg_avmm_addr,
  input  logic [3:0]               i_cfg_avmm_byte_en,
  input  logic                     i_cfg_avmm_read,
  input  logic                     i_cfg_avmm_write,
  input  logic [31:0]              i_cfg_avmm_wdata,
  output logic [31:0]              o_cfg_avmm_rdata,
  output logic                     o_cfg_avmm_rdatavld,
  output logic                     o_cfg_avmm_waitreq,
  input  logic [31:0]              i_status_set,
  output logic [NUM_REGS*32-1:0]   o_csr_flat,
  output logic [7:0]               o_err_cnt,
  output logic [1:0]               o_fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT     = 4'(WAIT_CYCLES - 1);
  localparam logic [14:0] NUM_REGS_IDX = 15'(NUM_REGS);

  state_t                 state;
  logic [3:0]             cnt;
  logic [NUM_REGS*32-1:0] csr_q;
  logic [NUM_REGS*32-1:0] csr_nxt;
  logic [31:0]            rdata_q;
  logic                   rdatavld_q;
  logic [7:0]             err_q;

  logic                   req;
  logic [14:0]            idx;
  logic                   in_range;
  logic                   accept;
  logic                   wr_hit;
  logic [31:0]            be_mask;
  logic [31:0]            w1c_clr;
  logic [31:0]            rd_word;
  logic                   ev_drop;
  logic                   ev_oor;
  logic                   ev_both;
  logic [1:0]             err_inc;
  logic [8:0]             err_sum;
  logic [7:0]             err_nxt;

  // Byte-lane bits of the address carry no meaning for a 32-bit CSR file.
  logic                   unused_addr_lsb;
  assign unused_addr_lsb = ^i_cfg_avmm_addr[1:0];

  assign req      = i_cfg_avmm_read | i_cfg_avmm_write;
  assign idx      = i_cfg_avmm_addr[16:2];
  assign in_range = (idx < NUM_REGS_IDX);
  assign accept   = (state == ST_ACK) && req;
  // A simultaneous read+write is handled as a write only.
  assign wr_hit   = accept && i_cfg_avmm_write && in_range;

  assign be_mask = {{8{i_cfg_avmm_byte_en[3]}}, {8{i_cfg_avmm_byte_en[2]}},
                    {8{i_cfg_avmm_byte_en[1]}}, {8{i_cfg_avmm_byte_en[0]}}};

  assign w1c_clr = (wr_hit && (idx == 15'd0)) ? (i_cfg_avmm_wdata & be_mask) : 32'd0;

  // Next CSR contents: byte-merged RW writes for 1..NUM_REGS-1, and the sticky
  // status register where a same-cycle set pulse overrides a W1C clear.
  always_comb begin
    csr_nxt = csr_q;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (wr_hit && (idx == 15'(k))) begin
        csr_nxt[k*32 +: 32] = (csr_q[k*32 +: 32] & ~be_mask) |
                              (i_cfg_avmm_wdata & be_mask);
      end
    end
    csr_nxt[31:0] = (csr_q[31:0] & ~w1c_clr) | i_status_set;
  end

  // Read mux; anything that decodes to no register returns the error pattern.
  always_comb begin
    rd_word = ERR_RDATA;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == 15'(k)) begin
        rd_word = csr_q[k*32 +: 32];
      end
    end
  end

  // Error events. A drop in WAIT cannot coincide with an accept, but an
  // out-of-range read+write is two independent faults and counts twice.
  assign ev_drop = (state == ST_WAIT) && !req;
  assign ev_oor  = accept && !in_range;
  assign ev_both = accept && i_cfg_avmm_read && i_cfg_avmm_write;
  assign err_inc = {1'b0, ev_drop} + {1'b0, ev_oor} + {1'b0, ev_both};
  assign err_sum = {1'b0, err_q} + {7'd0, err_inc};
  assign err_nxt = err_sum[8] ? 8'hFF : err_sum[7:0];

  // Access FSM plus all registered state of the block.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      csr_q      <= '0;
      rdata_q    <= 32'd0;
      rdatavld_q <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      csr_q      <= csr_nxt;
      err_q      <= err_nxt;
      rdata_q    <= 32'd0;
      rdatavld_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            cnt   <= CNT_INIT;
            state <= (WAIT_CYCLES == 1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            // Master abandoned the command: no side effects beyond the error.
            state <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          // Always back to IDLE so a held request starts a fresh access.
          state <= ST_IDLE;
          if (accept && i_cfg_avmm_read && !i_cfg_avmm_write) begin
            rdata_q    <= rd_word;
            rdatavld_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so that a fresh request is held off in the very
  // cycle it appears, and so that it reads high for the whole reset.
  assign o_cfg_avmm_waitreq  = !i_cfg_avmm_rst_n || (req && (state != ST_ACK));

  assign o_cfg_avmm_rdata    = rdata_q;
  assign o_cfg_avmm_rdatavld = rdatavld_q;
  assign o_csr_flat          = csr_q;
  assign o_err_cnt           = err_q;
  assign o_fsm_state         = state;

endmodule

// File: tb/tb_cfg_avmm_csr_slave.sv
// -----------------------------------------------------------------------------
// tb_cfg_avmm_csr_slave
//
// Bench for cfg_avmm_csr_slave with default parameters. A reference model
// (array of register values plus an error counter) is updated from the
// register-file rules whenever the bench's master sees a command accepted;
// expected read data goes through exp_q and is popped when rdatavld arrives.
// -----------------------------------------------------------------------------
module tb_cfg_avmm_csr_slave;

  localparam int          NUM_REGS    = 8;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_C0DE;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [16:0]            cfg_addr     = '0;
  logic [3:0]             cfg_byte_en  = '0;
  logic                   cfg_read     = 1'b0;
  logic                   cfg_write    = 1'b0;
  logic [31:0]            cfg_wdata    = '0;
  logic [31:0]            cfg_rdata;
  logic                   cfg_rdatavld;
  logic                   cfg_waitreq;
  logic [31:0]            status_set   = '0;
  logic [NUM_REGS*32-1:0] csr_flat;
  logic [7:0]             err_cnt;
  logic [1:0]             fsm_state;

  cfg_avmm_csr_slave #(
    .NUM_REGS    (NUM_REGS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .ERR_RDATA   (ERR_RDATA)
  ) dut (
    .i_cfg_avmm_clk      (clk),
    .i_cfg_avmm_rst_n    (rst_n),
    .i_cfg_avmm_addr     (cfg_addr),
    .i_cfg_avmm_byte_en  (cfg_byte_en),
    .i_cfg_avmm_read     (cfg_read),
    .i_cfg_avmm_write    (cfg_write),
    .i_cfg_avmm_wdata    (cfg_wdata),
    .o_cfg_avmm_rdata    (cfg_rdata),
    .o_cfg_avmm_rdatavld (cfg_rdatavld),
    .o_cfg_avmm_waitreq  (cfg_waitreq),
    .i_status_set        (status_set),
    .o_csr_flat          (csr_flat),
    .o_err_cnt           (err_cnt),
    .o_fsm_state         (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_regs [NUM_REGS];
  int          model_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 32'd0;
    model_err = 0;
    exp_q.delete();
  endfunction

  function automatic void model_error();
    if (model_err < 255) model_err++;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic check_flat(input string tag);
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("%s_flat%0d", tag, k), csr_flat[k*32 +: 32], model_regs[k]);
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.

  // One complete AVMM access. set_ack is driven on i_status_set during the
  // cycle whose edge accepts the command.
  task automatic do_access(input logic rd, input logic wr, input logic [16:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] set_ack, input string tag);
    int          waits = 0;
    bit          acked = 0;
    int          idx;
    bit          hit;
    logic [31:0] m;
    logic [31:0] got;
    cfg_addr = a; cfg_wdata = wd; cfg_byte_en = be;
    cfg_read = rd; cfg_write = wr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cfg_waitreq) begin
        acked = 1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    if (!acked) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      cfg_read = 1'b0; cfg_write = 1'b0;
      @(posedge clk); #1;
      return;
    end
    status_set = set_ack;
    @(posedge clk);
    // Reference model: the command takes effect on this edge.
    idx = int'(a[16:2]);
    hit = (idx < NUM_REGS);
    m   = lane_mask(be);
    if (wr) begin
      if (!hit) model_error();
      else if (idx == 0) model_regs[0] = model_regs[0] & ~(wd & m);
      else model_regs[idx] = (model_regs[idx] & ~m) | (wd & m);
      if (rd) model_error();
    end else begin
      exp_q.push_back(hit ? model_regs[idx] : ERR_RDATA);
      if (!hit) model_error();
    end
    model_regs[0] = model_regs[0] | set_ack;
    #1;
    cfg_read = 1'b0; cfg_write = 1'b0; status_set = 32'd0;
    check({tag, "_waits"}, 32'(waits), 32'(WAIT_CYCLES));
    @(negedge clk);
    if (rd && !wr) begin
      check({tag, "_rdvld"}, 32'(cfg_rdatavld), 32'd1);
      got = cfg_rdata;
      if (exp_q.size() == 0) check({tag, "_rd_noexp"}, 32'd0, 32'd1);
      else check({tag, "_rdata"}, got, exp_q.pop_front());
    end else begin
      check({tag, "_no_rdvld"}, 32'(cfg_rdatavld), 32'd0);
      check({tag, "_rdata0"}, cfg_rdata, 32'd0);
    end
    check({tag, "_err"}, 32'(err_cnt), 32'(model_err));
    check_flat(tag);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_vld_pulse"}, 32'(cfg_rdatavld), 32'd0);
    check({tag, "_rdata_idle"}, cfg_rdata, 32'd0);
    @(posedge clk); #1;
  endtask

  // Start a read, then abandon it while the slave is still stalling.
  task automatic do_drop(input logic [16:0] a, input string tag);
    cfg_addr = a; cfg_read = 1'b1; cfg_write = 1'b0;
    @(negedge clk);
    check({tag, "_stall"}, 32'(cfg_waitreq), 32'd1);
    @(posedge clk); #1;
    cfg_read = 1'b0;
    @(posedge clk); #1;
    model_error();
    @(negedge clk);
    check({tag, "_err"}, 32'(err_cnt), 32'(model_err));
    check({tag, "_no_rdvld"}, 32'(cfg_rdatavld), 32'd0);
    check({tag, "_idle_wr"}, 32'(cfg_waitreq), 32'd0);
    check_flat(tag);
    @(posedge clk); #1;
  endtask

  task automatic pulse_status(input logic [31:0] bits, input string tag);
    status_set = bits;
    @(posedge clk); #1;
    status_set = 32'd0;
    model_regs[0] = model_regs[0] | bits;
    @(negedge clk);
    check({tag, "_status"}, csr_flat[31:0], model_regs[0]);
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] mk_addr(input int idx);
    logic [1:0] lsb;
    lsb = 2'($urandom_range(0, 3));
    return {15'(idx), lsb};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int          op;
    int          idx;
    logic [16:0] a;
    model_reset();

    // Reset state.
    #1;
    check("rst_waitreq", 32'(cfg_waitreq), 32'd1);
    check("rst_rdvld", 32'(cfg_rdatavld), 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check_flat("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_waitreq", 32'(cfg_waitreq), 32'd0);
    @(posedge clk); #1;

    // Basic write/read of register 1.
    do_access(1'b0, 1'b1, 17'h00004, 32'hA5A5_1234, 4'hF, 32'd0, "wr1");
    do_access(1'b1, 1'b0, 17'h00004, 32'd0, 4'h0, 32'd0, "rd1");

    // Byte enables on register 2.
    do_access(1'b0, 1'b1, 17'h00008, 32'hFFFF_FFFF, 4'hF, 32'd0, "wr2_ones");
    do_access(1'b0, 1'b1, 17'h00008, 32'h0000_0000, 4'b0101, 32'd0, "wr2_be");
    do_access(1'b1, 1'b0, 17'h00008, 32'd0, 4'h0, 32'd0, "rd2_be");
    check("rd2_be_value", model_regs[2], 32'hFF00_FF00);

    // Sticky status and the set-over-clear race.
    pulse_status(32'h0000_0011, "st11");
    do_access(1'b0, 1'b1, 17'h00000, 32'h0000_0011, 4'hF, 32'h0000_0001, "w1c_race");
    do_access(1'b1, 1'b0, 17'h00000, 32'd0, 4'h0, 32'd0, "rd0");

    // Decode errors.
    do_access(1'b1, 1'b0, 17'h00100, 32'd0, 4'h0, 32'd0, "rd_oor");
    do_access(1'b0, 1'b1, 17'h00100, 32'h1234_5678, 4'hF, 32'd0, "wr_oor");

    // Protocol errors.
    do_access(1'b1, 1'b1, 17'h0000C, 32'hCAFE_F00D, 4'hF, 32'd0, "both");
    do_drop(17'h00004, "drop");
    do_access(1'b1, 1'b0, 17'h0000C, 32'd0, 4'h0, 32'd0, "rd_after_drop");

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: do_access(1'b0, 1'b1, mk_addr($urandom_range(0, NUM_REGS-1)), $urandom,
                     4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? $urandom : 32'd0, "r_wr");
        1: do_access(1'b1, 1'b0, mk_addr($urandom_range(0, NUM_REGS-1)), 32'd0, 4'h0,
                     32'd0, "r_rd");
        2: do_access(1'b1, 1'b0, mk_addr($urandom_range(NUM_REGS, 32767)), 32'd0, 4'h0,
                     32'd0, "r_rd_oor");
        3: do_access(1'b0, 1'b1, mk_addr($urandom_range(NUM_REGS, 32767)), $urandom,
                     4'($urandom_range(0, 15)), 32'd0, "r_wr_oor");
        4: do_access(1'b1, 1'b1, mk_addr($urandom_range(0, NUM_REGS-1)), $urandom,
                     4'($urandom_range(0, 15)), 32'd0, "r_both");
        5: pulse_status($urandom & $urandom, "r_st");
        default: do_drop(mk_addr($urandom_range(0, NUM_REGS-1)), "r_drop");
      endcase
    end

    // Reset in the middle of a stalled access.
    do_access(1'b0, 1'b1, 17'h00014, 32'h0BAD_BEEF, 4'hF, 32'd0, "pre_rst");
    cfg_addr = 17'h00014; cfg_read = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_waitreq", 32'(cfg_waitreq), 32'd1);
    check("midrst_rdvld", 32'(cfg_rdatavld), 32'd0);
    check("midrst_err", 32'(err_cnt), 32'd0);
    check_flat("midrst");
    cfg_read = 1'b0;
    @(posedge clk); #1;
    check("midrst_hold_rdvld", 32'(cfg_rdatavld), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_waitreq", 32'(cfg_waitreq), 32'd0);
    check("postrst_rdvld", 32'(cfg_rdatavld), 32'd0);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 17'h00014, 32'd0, 4'h0, 32'd0, "postrst_rd");

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(NUM_REGS, 32767);
      a   = mk_addr(idx);
      do_access(1'b1, 1'b0, a, 32'd0, 4'h0, 32'd0, "sat");
    end
    check("err_saturated", 32'(err_cnt), 32'h0000_00FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound in case a wait inside a task never resolves.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
